cos_request_sequencer: RTL and testbench

//  Initiator for the cosine engine's start/x/done interface. Buffers angle

---
 rtl/cos_request_sequencer.sv | 172 +++++++++++++++++
 tb/tb_cos_request_sequencer.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cos_request_sequencer.sv
// Request sequencer for the cosine engine: queues angles in a small FIFO, runs one
// start/done transaction at a time and returns each result with its angle on a valid/ready port.
module cos_request_sequencer #(
    parameter int unsigned Depth   = 4,    // power of 2, >= 2
    parameter int unsigned XW      = 10,
    parameter int unsigned FracW   = 8,
    parameter int unsigned Timeout = 255   // >= 1
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [XW-1:0]              in_x_i,
    input  logic [7:0]                 y_cfg_i,
    output logic                       eng_start_o,
    output logic [XW-1:0]              eng_x_o,
    output logic [7:0]                 eng_y_o,
    input  logic [1:0]                 eng_intpart_i,
    input  logic [FracW-1:0]           eng_fracpart_i,
    input  logic                       eng_done_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [XW-1:0]              out_x_o,
    output logic [1:0]                 out_int_o,
    output logic [FracW-1:0]           out_frac_o,
    output logic                       out_timeout_o,
    output logic                       busy_o,
    output logic [$clog2(Depth):0]     level_o
);

    localparam int unsigned PtrW   = $clog2(Depth);
    localparam int unsigned TimerW = $clog2(Timeout + 1);
    localparam logic [PtrW:0]     Full      = (PtrW + 1)'(Depth);
    localparam logic [TimerW-1:0] TimerLast = TimerW'(Timeout - 1);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StHold} state_e;

    state_e state_q, state_d;

    logic [XW-1:0]     mem_q [Depth];
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PtrW:0]     count_q, count_d;
    logic [XW-1:0]     eng_x_q, eng_x_d;
    logic [7:0]        eng_y_q, eng_y_d;
    logic [TimerW-1:0] timer_q, timer_d;
    logic [XW-1:0]     out_x_q, out_x_d;
    logic [1:0]        out_int_q, out_int_d;
    logic [FracW-1:0]  out_frac_q, out_frac_d;
    logic              out_timeout_q, out_timeout_d;

    logic push, pop, timer_expired;

    assign in_ready_o    = (count_q != Full);
    assign push          = in_valid_i & in_ready_o;
    assign pop           = (state_q == StIdle) && (count_q != '0);
    // Timer holds the number of completed WAIT cycles, so expiry lands on WAIT cycle Timeout.
    assign timer_expired = (timer_q == TimerLast);

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (count_q != '0) state_d = StIssue;
            StIssue: state_d = StWait;
            StWait:  if (eng_done_i || timer_expired) state_d = StHold;
            StHold:  if (out_ready_i) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Output logic
    always_comb begin
        eng_start_o = (state_q == StIssue);
        out_valid_o = (state_q == StHold);
        busy_o      = (state_q != StIdle);
    end

    // FIFO storage carries no reset; occupancy is governed by the pointers and count.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_x_i;
        end
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end

        eng_x_d = eng_x_q;
        eng_y_d = eng_y_q;
        if (pop) begin
            eng_x_d = mem_q[rd_ptr_q];
            eng_y_d = y_cfg_i;
        end

        timer_d = timer_q;
        if (state_q == StIssue) begin
            timer_d = '0;
        end else if (state_q == StWait) begin
            timer_d = timer_q + 1'b1;
        end

        out_x_d       = out_x_q;
        out_int_d     = out_int_q;
        out_frac_d    = out_frac_q;
        out_timeout_d = out_timeout_q;
        if (state_q == StWait) begin
            // A late done still beats the timeout in the same cycle.
            if (eng_done_i) begin
                out_x_d       = eng_x_q;
                out_int_d     = eng_intpart_i;
                out_frac_d    = eng_fracpart_i;
                out_timeout_d = 1'b0;
            end else if (timer_expired) begin
                out_x_d       = eng_x_q;
                out_int_d     = '0;
                out_frac_d    = '0;
                out_timeout_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            eng_x_q       <= '0;
            eng_y_q       <= '0;
            timer_q       <= '0;
            out_x_q       <= '0;
            out_int_q     <= '0;
            out_frac_q    <= '0;
            out_timeout_q <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            eng_x_q       <= eng_x_d;
            eng_y_q       <= eng_y_d;
            timer_q       <= timer_d;
            out_x_q       <= out_x_d;
            out_int_q     <= out_int_d;
            out_frac_q    <= out_frac_d;
            out_timeout_q <= out_timeout_d;
        end
    end

    assign eng_x_o       = eng_x_q;
    assign eng_y_o       = eng_y_q;
    assign out_x_o       = out_x_q;
    assign out_int_o     = out_int_q;
    assign out_frac_o    = out_frac_q;
    assign out_timeout_o = out_timeout_q;
    assign level_o       = count_q;

endmodule

// File: tb/tb_cos_request_sequencer.sv
// Directed bench for cos_request_sequencer with a behavioural engine model and a
// result scoreboard; expectations are queued at push time and compared at each handshake.
module tb_cos_request_sequencer;

    localparam int unsigned Depth   = 4;
    localparam int unsigned XW      = 10;
    localparam int unsigned FracW   = 8;
    localparam int unsigned Timeout = 255;
    localparam int unsigned LW      = $clog2(Depth) + 1;

    typedef logic [XW+FracW+2:0] exp_t;  // {x, int, frac, timeout}

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [XW-1:0]    in_x = '0;
    logic [7:0]       y_cfg = '0;
    logic             eng_start;
    logic [XW-1:0]    eng_x;
    logic [7:0]       eng_y;
    logic [1:0]       eng_intpart;
    logic [FracW-1:0] eng_fracpart;
    logic             eng_done;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [XW-1:0]    out_x;
    logic [1:0]       out_int;
    logic [FracW-1:0] out_frac;
    logic             out_timeout;
    logic             busy;
    logic [LW-1:0]    level;

    always #5 clk = ~clk;

    cos_request_sequencer #(
        .Depth   (Depth),
        .XW      (XW),
        .FracW   (FracW),
        .Timeout (Timeout)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .in_valid_i     (in_valid),
        .in_ready_o     (in_ready),
        .in_x_i         (in_x),
        .y_cfg_i        (y_cfg),
        .eng_start_o    (eng_start),
        .eng_x_o        (eng_x),
        .eng_y_o        (eng_y),
        .eng_intpart_i  (eng_intpart),
        .eng_fracpart_i (eng_fracpart),
        .eng_done_i     (eng_done),
        .out_valid_o    (out_valid),
        .out_ready_i    (out_ready),
        .out_x_o        (out_x),
        .out_int_o      (out_int),
        .out_frac_o     (out_frac),
        .out_timeout_o  (out_timeout),
        .busy_o         (busy),
        .level_o        (level)
    );

    int n_checks = 0;
    int n_fail = 0;
    int n_starts = 0;
    int n_results = 0;
    int full_seen = 0;
    int cyc = 0;
    exp_t sb_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Engine model: answers eng_delay cycles after start unless muted.
    logic             eng_mute = 1'b0;
    int               eng_delay = 5;
    int               eng_cnt = 0;
    logic             model_done = 1'b0;
    logic             force_done = 1'b0;
    logic [XW-1:0]    eng_lat_x = '0;
    logic [1:0]       eng_int_r = '0;
    logic [FracW-1:0] eng_frac_r = '0;

    function automatic logic [1:0] model_int(input logic [XW-1:0] x);
        return x[9:8] ^ 2'b01;
    endfunction

    function automatic logic [FracW-1:0] model_frac(input logic [XW-1:0] x);
        return x[7:0] ^ 8'h92;
    endfunction

    function automatic exp_t expect_of(input logic [XW-1:0] x);
        if (eng_mute) return {x, 2'b00, 8'h00, 1'b1};
        return {x, model_int(x), model_frac(x), 1'b0};
    endfunction

    assign eng_done     = model_done | force_done;
    assign eng_intpart  = force_done ? 2'b11 : eng_int_r;
    assign eng_fracpart = force_done ? 8'hEE : eng_frac_r;

    initial forever begin
        @(negedge clk);
        model_done = 1'b0;
        if (rst_n !== 1'b1) begin
            eng_cnt = 0;
        end else if (eng_start) begin
            eng_cnt   = eng_mute ? 0 : eng_delay;
            eng_lat_x = eng_x;
        end else if (eng_cnt > 0) begin
            eng_cnt--;
            if (eng_cnt == 0) begin
                model_done = 1'b1;
                eng_int_r  = model_int(eng_lat_x);
                eng_frac_r = model_frac(eng_lat_x);
            end
        end
    end

    // Monitor: scoreboard compare on every accepted result.
    initial forever begin
        @(negedge clk);
        if (rst_n === 1'b1) begin
            if (eng_start) begin
                n_starts++;
                check("start_during_hold", out_valid, 0);
            end
            if (level == LW'(Depth)) begin
                full_seen++;
                check("full_in_ready", in_ready, 0);
            end
            if (out_valid && out_ready) begin
                n_results++;
                check("sb_nonempty", sb_q.size() > 0, 1);
                if (sb_q.size() > 0) begin
                    check("result", {out_x, out_int, out_frac, out_timeout}, sb_q.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [XW-1:0] x);
        logic ok = 1'b0;
        in_valid = 1'b1;
        in_x     = x;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check("push_accept", ok, 1);
        if (ok) sb_q.push_back(expect_of(x));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(input int max, output logic ok);
        ok = 1'b0;
        for (int k = 0; k < max; k++) begin
            @(negedge clk);
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_start(input int max, output logic ok);
        ok = 1'b0;
        for (int k = 0; k < max; k++) begin
            @(negedge clk);
            if (eng_start) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_results(input string tag, input int target, input int max);
        logic ok = 1'b0;
        for (int k = 0; k < max; k++) begin
            tick();
            if (n_results >= target) begin
                ok = 1'b1;
                break;
            end
        end
        check(tag, ok, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no end of test, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic ok;
        int   cs, r0, s0;
        exp_t snap;
        logic still;

        // Reset state
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        check("rst_in_ready", in_ready, 1);
        check("rst_level", level, 0);
        check("rst_busy", busy, 0);
        check("rst_eng", {eng_start, eng_x, eng_y}, 0);
        check("rst_out", {out_valid, out_x, out_int, out_frac, out_timeout}, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // 1: single request, engine answers 5 cycles after start
        y_cfg     = 8'hA5;
        eng_delay = 5;
        push(10'h180);
        wait_start(20, ok);
        check("t1_start_seen", ok, 1);
        check("t1_eng_x", eng_x, 10'h180);
        check("t1_eng_y", eng_y, 8'hA5);
        cs = cyc;
        tick();
        y_cfg = 8'h3C;
        wait_valid(20, ok);
        check("t1_valid_seen", ok, 1);
        check("t1_latency", cyc - cs, 6);
        check("t1_out_x", out_x, 10'h180);
        check("t1_out_int", out_int, 2'b00);
        check("t1_out_frac", out_frac, 8'h12);
        check("t1_out_timeout", out_timeout, 0);
        check("t1_eng_y_held", eng_y, 8'hA5);
        wait_results("t1_result", 1, 20);
        check("t1_single_start", n_starts, 1);

        // 2: six back-to-back pushes into a 4-deep FIFO
        eng_delay = 3;
        r0 = n_results;
        for (int i = 0; i < 6; i++) push(10'(64 + i * 37));
        wait_results("t2_results", r0 + 6, 300);
        check("t2_full_reached", full_seen > 0, 1);

        // 3: consumer stalls 20 cycles
        out_ready = 1'b0;
        r0 = n_results;
        push(10'h2A1);
        push(10'h155);
        wait_valid(30, ok);
        check("t3_valid_seen", ok, 1);
        snap = {out_x, out_int, out_frac, out_timeout};
        #1;
        s0 = n_starts;
        still = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!out_valid || {out_x, out_int, out_frac, out_timeout} != snap) still = 1'b0;
        end
        check("t3_frozen", still, 1);
        #1;
        check("t3_no_start", n_starts, s0);
        tick();
        out_ready = 1'b1;
        cs = cyc;
        wait_start(10, ok);
        check("t3_start_seen", ok, 1);
        check("t3_issue_gap", cyc - cs, 2);
        wait_results("t3_results", r0 + 2, 50);

        // 4: engine never answers
        eng_mute = 1'b1;
        r0 = n_results;
        push(10'h0FF);
        wait_start(10, ok);
        check("t4_start_seen", ok, 1);
        cs = cyc;
        wait_valid(Timeout + 20, ok);
        check("t4_valid_seen", ok, 1);
        check("t4_timeout_latency", cyc - cs, Timeout + 1);
        check("t4_timeout_flag", out_timeout, 1);
        check("t4_zero_result", {out_int, out_frac}, 0);
        tick();
        eng_mute = 1'b0;
        push(10'h33A);
        wait_results("t4_results", r0 + 2, 50);

        // 5: stale done in IDLE and in HOLD
        tick();
        check("t5_idle", busy, 0);
        snap = {out_x, out_int, out_frac, out_timeout};
        force_done = 1'b1;
        still = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (busy || out_valid || {out_x, out_int, out_frac, out_timeout} != snap) still = 1'b0;
        end
        force_done = 1'b0;
        check("t5_idle_done_ignored", still, 1);
        tick();
        out_ready = 1'b0;
        r0 = n_results;
        push(10'h1C7);
        wait_valid(20, ok);
        check("t5_valid_seen", ok, 1);
        snap = {out_x, out_int, out_frac, out_timeout};
        tick();
        force_done = 1'b1;
        still = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (!out_valid || {out_x, out_int, out_frac, out_timeout} != snap) still = 1'b0;
        end
        check("t5_hold_done_ignored", still, 1);
        tick();
        force_done = 1'b0;
        out_ready  = 1'b1;
        wait_results("t5_results", r0 + 1, 20);

        // 6: reset during WAIT with three requests queued
        eng_delay = 50;
        for (int i = 0; i < 4; i++) push(10'(256 + i));
        check("t6_level_before", level, 3);
        check("t6_busy_before", busy, 1);
        rst_n = 1'b0;
        #1;
        check("t6_level", level, 0);
        check("t6_in_ready", in_ready, 1);
        check("t6_busy", busy, 0);
        check("t6_eng", {eng_start, eng_x, eng_y}, 0);
        check("t6_out", {out_valid, out_x, out_int, out_frac, out_timeout}, 0);
        sb_q.delete();
        tick();
        tick();
        rst_n = 1'b1;
        s0 = n_starts;
        repeat (10) tick();
        check("t6_no_start", n_starts, s0);
        check("t6_level_after", level, 0);
        eng_delay = 2;
        r0 = n_results;
        push(10'h2F0);
        wait_results("t6_results", r0 + 1, 30);

        check("sb_empty", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
